// File: rtl/chan_scan_mux.sv
// chan_scan_mux
//   Registered N-to-1 channel selector with two modes:
//     direct (mode=0): one select transaction per valid/ready handshake,
//                      result held in a single full-throughput output stage.
//     scan   (mode=1): free-running sweep over all channels, each channel
//                      held SCAN_DIV cycles, for time-multiplexed displays.
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     in                  packed channels, channel k = in[k*WIDTH +: WIDTH]
//     mode                0 = direct, 1 = scan (registered into mode_q)
//     select, sel_valid   direct-mode request; sel_ready accepts it
//     out, out_sel        registered data and the channel index it came from
//     out_valid,out_ready output handshake (out_ready ignored in scan mode)
//     sel_err             1 = out came from an out-of-range select
//     scan_tick           one-cycle pulse when the scan index advances
module chan_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic                      scan_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic             mode_q;
  logic [SEL_W-1:0] idx;
  logic [DIV_W-1:0] div;

  logic             mode_sw;
  logic             sel_in_range;
  logic             div_tc;
  logic             idx_last;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] scan_data;

  // A mode change is acted on only once it has been seen by mode_q; the
  // edge where they disagree just flushes state.
  assign mode_sw      = (mode != mode_q);
  assign sel_in_range = (32'(select) < 32'(CHANNELS));
  assign div_tc       = (div == DIV_W'(SCAN_DIV - 1));
  assign idx_last     = (idx == SEL_W'(CHANNELS - 1));

  // Out-of-range selects read as zero rather than whatever lies past the bus.
  assign sel_data  = sel_in_range ? in[32'(select)*WIDTH +: WIDTH] : '0;
  // idx is kept below CHANNELS by the wrap logic, so no guard is needed.
  assign scan_data = in[32'(idx)*WIDTH +: WIDTH];

  // Pipeline-register style ready: a consumed result frees the slot in the
  // same cycle, so back-to-back selects run at full rate.
  assign sel_ready = !mode_q && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      idx       <= '0;
      div       <= '0;
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_sw) begin
        // Any pending direct result is dropped; the sweep restarts at 0.
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
        idx       <= '0;
        div       <= '0;
        scan_tick <= 1'b0;
      end else if (mode_q) begin
        out       <= scan_data;
        out_sel   <= idx;
        out_valid <= 1'b1;
        sel_err   <= 1'b0;
        if (div_tc) begin
          div       <= '0;
          idx       <= idx_last ? '0 : idx + 1'b1;
          scan_tick <= 1'b1;
        end else begin
          div       <= div + 1'b1;
          scan_tick <= 1'b0;
        end
      end else begin
        scan_tick <= 1'b0;
        if (sel_valid && sel_ready) begin
          out       <= sel_data;
          out_sel   <= select;
          out_valid <= 1'b1;
          sel_err   <= !sel_in_range;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: a 16-channel instance (SCAN_DIV=4) and a
// 12-channel instance share stimulus. Direct mode is checked against a
// transaction-level handshake model; scan mode against a closed-form
// position derived from the number of edges since the sweep started.
module tb_chan_scan_mux;
  localparam int W = 8;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [16*W-1:0] in16;
  logic [12*W-1:0] in12;
  logic            mode = 1'b0;
  logic [3:0]      select = '0;
  logic            sel_valid = 1'b0;
  logic            out_ready = 1'b0;

  logic       a_sel_ready, a_out_valid, a_sel_err, a_scan_tick;
  logic [7:0] a_out;
  logic [3:0] a_out_sel;
  logic       b_sel_ready, b_out_valid, b_sel_err, b_scan_tick;
  logic [7:0] b_out;
  logic [3:0] b_out_sel;

  int vectors = 0;
  int errs    = 0;

  assign in12 = in16[12*W-1:0];

  wire [13:0] a_obs = {a_out, a_out_sel, a_out_valid, a_sel_err};
  wire [13:0] b_obs = {b_out, b_out_sel, b_out_valid, b_sel_err};

  chan_scan_mux #(.WIDTH(W), .CHANNELS(16), .SEL_W(4), .SCAN_DIV(D)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in16), .mode(mode), .select(select),
    .sel_valid(sel_valid), .sel_ready(a_sel_ready), .out(a_out),
    .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(out_ready),
    .sel_err(a_sel_err), .scan_tick(a_scan_tick));

  chan_scan_mux #(.WIDTH(W), .CHANNELS(12), .SEL_W(4), .SCAN_DIV(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in12), .mode(mode), .select(select),
    .sel_valid(sel_valid), .sel_ready(b_sel_ready), .out(b_out),
    .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(out_ready),
    .sel_err(b_sel_err), .scan_tick(b_scan_tick));

  always #5 clk = ~clk;

  function automatic logic [7:0] chan(int k);
    return in16[k*W +: W];
  endfunction

  task automatic init_in();
    for (int k = 0; k < 16; k++) in16[k*W +: W] = 8'(8'h11 * k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({a_obs, a_scan_tick} !== 15'd0) begin
      errs++; $display("FAIL reset_a: got %h want 0", {a_obs, a_scan_tick});
    end
    vectors++;
    if ({b_obs, b_scan_tick} !== 15'd0) begin
      errs++; $display("FAIL reset_b: got %h want 0", {b_obs, b_scan_tick});
    end
    // Inputs active while reset held: must have no effect.
    mode = 1'b1; sel_valid = 1'b1; select = 4'd5;
    tick(); tick();
    vectors++;
    if ({a_obs, a_scan_tick} !== 15'd0) begin
      errs++; $display("FAIL reset_hold: got %h want 0", {a_obs, a_scan_tick});
    end
    mode = 1'b0; sel_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (a_sel_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready: got %b want 1", a_sel_ready);
    end
  endtask

  task automatic test_direct_basic();
    select = 4'd5; sel_valid = 1'b1; out_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (a_obs !== {8'h55, 4'd5, 2'b10}) begin
      errs++; $display("FAIL direct_basic: got %h want %h", a_obs, {8'h55, 4'd5, 2'b10});
    end
    tick();
    vectors++;
    if (a_obs !== {8'h55, 4'd5, 2'b00}) begin
      errs++; $display("FAIL direct_consume: got %h want %h", a_obs, {8'h55, 4'd5, 2'b00});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; select = 4'd3; sel_valid = 1'b1;
    tick();
    select = 4'd9;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (a_sel_ready !== 1'b0) begin
        errs++; $display("FAIL bp_ready cyc %0d: got %b want 0", i, a_sel_ready);
      end
      vectors++;
      if (a_obs !== {8'h33, 4'd3, 2'b10}) begin
        errs++; $display("FAIL bp_hold cyc %0d: got %h want %h", i, a_obs, {8'h33, 4'd3, 2'b10});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (a_sel_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release_ready: got %b want 1", a_sel_ready);
    end
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (a_obs !== {8'h99, 4'd9, 2'b10}) begin
      errs++; $display("FAIL bp_replace: got %h want %h", a_obs, {8'h99, 4'd9, 2'b10});
    end
    tick();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_drain: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_out_of_range();
    int sels [6] = '{14, 2, 11, 12, 15, 0};
    logic [13:0] exp_b, exp_a;
    out_ready = 1'b1;
    foreach (sels[i]) begin
      select = 4'(sels[i]); sel_valid = 1'b1;
      tick();
      exp_a = {chan(sels[i]), 4'(sels[i]), 2'b10};
      exp_b = (sels[i] >= 12) ? {8'h00, 4'(sels[i]), 2'b11}
                              : {chan(sels[i]), 4'(sels[i]), 2'b10};
      vectors++;
      if (b_obs !== exp_b) begin
        errs++; $display("FAIL range12 sel %0d: got %h want %h", sels[i], b_obs, exp_b);
      end
      vectors++;
      if (a_obs !== exp_a) begin
        errs++; $display("FAIL range16 sel %0d: got %h want %h", sels[i], a_obs, exp_a);
      end
    end
    sel_valid = 1'b0;
  endtask

  // Transaction model: one output slot per instance, filled by an accepted
  // select, emptied by a consume, refilled in the same cycle if both happen.
  task automatic test_random_direct(int n);
    logic [7:0] m_out [2];
    logic [3:0] m_sel [2];
    logic       m_v [2];
    logic       m_e [2];
    int         nch [2] = '{16, 12};
    logic       rdy [2];
    logic [13:0] obs [2];
    logic       ticks [2];
    logic       exp_rdy;
    mode = 1'b0; select = 4'd0; sel_valid = 1'b1; out_ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = chan(0); m_sel[d] = 4'd0; m_v[d] = 1'b1; m_e[d] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      sel_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      select    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        in16[$urandom_range(0, 15)*W +: W] = 8'($urandom);
      #1;
      rdy[0] = a_sel_ready; rdy[1] = b_sel_ready;
      for (int d = 0; d < 2; d++) begin
        exp_rdy = !m_v[d] || out_ready;
        vectors++;
        if (rdy[d] !== exp_rdy) begin
          errs++; $display("FAIL rand_ready dut%0d cyc %0d: got %b want %b", d, c, rdy[d], exp_rdy);
        end
        if (sel_valid && exp_rdy) begin
          m_v[d]   = 1'b1;
          m_sel[d] = select;
          m_e[d]   = (int'(select) >= nch[d]);
          m_out[d] = m_e[d] ? 8'h00 : chan(int'(select));
        end else if (m_v[d] && out_ready) begin
          m_v[d] = 1'b0;
        end
      end
      tick();
      obs[0] = a_obs; obs[1] = b_obs;
      ticks[0] = a_scan_tick; ticks[1] = b_scan_tick;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({obs[d], ticks[d]} !== {m_out[d], m_sel[d], m_v[d], m_e[d], 1'b0}) begin
          errs++;
          $display("FAIL rand_out dut%0d cyc %0d: got %h want %h", d, c,
                   {obs[d], ticks[d]}, {m_out[d], m_sel[d], m_v[d], m_e[d], 1'b0});
        end
      end
    end
    sel_valid = 1'b0;
  endtask

  // After the switch edge, scan edge e shows channel ((e-1)/D) mod 16 and
  // the tick pulse follows every D-th edge.
  task automatic test_scan();
    int          ei;
    logic [13:0] exp_o;
    logic        exp_t;
    init_in();
    mode = 1'b1; sel_valid = 1'b0;
    tick();
    vectors++;
    if ({a_out_valid, a_sel_err, a_scan_tick} !== 3'b000) begin
      errs++; $display("FAIL scan_switch: got %b want 000", {a_out_valid, a_sel_err, a_scan_tick});
    end
    for (int e = 1; e <= 70; e++) begin
      sel_valid = 1'($urandom_range(0, 1));
      select    = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (e == 30) in16[7*W +: W] = 8'($urandom_range(0, 255) ^ 8'h77) | 8'h80;
      #1;
      vectors++;
      if (a_sel_ready !== 1'b0) begin
        errs++; $display("FAIL scan_ready e %0d: got %b want 0", e, a_sel_ready);
      end
      ei    = ((e - 1) / D) % 16;
      exp_o = {chan(ei), 4'(ei), 2'b10};
      exp_t = (e % D == 0);
      tick();
      vectors++;
      if ({a_obs, a_scan_tick} !== {exp_o, exp_t}) begin
        errs++; $display("FAIL scan e %0d: got %h want %h", e, {a_obs, a_scan_tick}, {exp_o, exp_t});
      end
    end
    sel_valid = 1'b0;
    init_in();
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; out_ready = 1'b0;
    tick();
    vectors++;
    if ({a_out_valid, a_scan_tick} !== 2'b00) begin
      errs++; $display("FAIL sw_to_direct: got %b want 00", {a_out_valid, a_scan_tick});
    end
    select = 4'd4; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (a_obs !== {8'h44, 4'd4, 2'b10}) begin
      errs++; $display("FAIL sw_pending: got %h want %h", a_obs, {8'h44, 4'd4, 2'b10});
    end
    mode = 1'b1;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      errs++; $display("FAIL sw_discard: got %b want 0", a_out_valid);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (a_obs !== {chan(0), 4'd0, 2'b10}) begin
        errs++; $display("FAIL sw_scan0 e %0d: got %h want %h", e, a_obs, {chan(0), 4'd0, 2'b10});
      end
    end
    mode = 1'b0;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      errs++; $display("FAIL sw_back: got %b want 0", a_out_valid);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      errs++; $display("FAIL sw_idle: got %b want 0", a_out_valid);
    end
    select = 4'd6; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (a_obs !== {8'h66, 4'd6, 2'b10}) begin
      errs++; $display("FAIL sw_handshake: got %h want %h", a_obs, {8'h66, 4'd6, 2'b10});
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; sel_valid = 1'b0;
    tick();
    repeat (25) tick();
    vectors++;
    if (a_obs !== {chan(6), 4'd6, 2'b10}) begin
      errs++; $display("FAIL ar_pre: got %h want %h", a_obs, {chan(6), 4'd6, 2'b10});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_obs, a_scan_tick} !== 15'd0) begin
      errs++; $display("FAIL ar_immediate: got %h want 0", {a_obs, a_scan_tick});
    end
    vectors++;
    if (a_sel_ready !== 1'b1) begin
      errs++; $display("FAIL ar_direct: got %b want 1", a_sel_ready);
    end
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (a_obs !== 14'd0) begin
      errs++; $display("FAIL ar_idle: got %h want 0", a_obs);
    end
    select = 4'd3; sel_valid = 1'b1; out_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (a_obs !== {8'h33, 4'd3, 2'b10}) begin
      errs++; $display("FAIL ar_after: got %h want %h", a_obs, {8'h33, 4'd3, 2'b10});
    end
  endtask

  initial begin
    init_in();
    test_reset();
    test_direct_basic();
    test_backpressure();
    test_out_of_range();
    test_random_direct(400);
    test_scan();
    test_mode_switch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
Parametrised, registered N-to-1 channel selector. It replaces the fixed 16x8 combinational mux used on the multicycle CPU debug/display path. It supports two modes:
- Direct mode: a select transaction with valid/ready handshake on both sides.
- Scan mode: a free-running channel sweep that drives time-multiplexed display digits.

Parameters:
WIDTH, 8, bits per channel
CHANNELS, 16, number of input channels (2..256)
SEL_W, 4, select width; must satisfy 2**SEL_W >= CHANNELS
SCAN_DIV, 16, clock cycles each channel is held in scan mode (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in  input  CHANNELS*WIDTH  packed channels; channel k = in[(k+1)*WIDTH-1 : k*WIDTH]
mode  input  1  0 = direct, 1 = scan
select  input  SEL_W  requested channel (direct mode)
sel_valid  input  1  select request valid
sel_ready  output  1  block can accept a select
out  output  WIDTH  registered selected data
out_sel  output  SEL_W  channel index that produced out
out_valid  output  1  out holds an unconsumed result
out_ready  input  1  consumer accepts out
sel_err  output  1  registered alongside out; 1 = out-of-range select
scan_tick  output  1  one-cycle pulse when scan index advances

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports clk and rst_n.
- Reset (rst_n = 0, takes effect immediately regardless of clk):
  - out, out_sel, out_valid, sel_err and scan_tick are all 0.
  - Scan index and divider counter are 0.
  - Internal mode register is 0 (direct).
- Mode is sampled every edge into mode_q. The first edge at which mode differs from mode_q is the switch edge.
  - On the switch edge: out_valid <= 0, sel_err <= 0, scan index <= 0, divider <= 0, scan_tick <= 0. Any pending direct result is discarded.
  - The new mode's behaviour begins on the following edge.
- Direct mode (mode_q = 0):
  - sel_ready = !out_valid || out_ready (combinational; full-throughput pipeline register).
  - Transfer occurs when sel_valid && sel_ready at a rising edge. On that edge:
    - out <= channel[select]
    - out_sel <= select
    - out_valid <= 1
    - sel_err <= (select >= CHANNELS)
  - Latency: 1 cycle from the accepting edge to out_valid.
  - Out-of-range select gives out <= 0, sel_err <= 1, and the handshake still completes.
  - If out_valid && out_ready and there is no new transfer, out_valid <= 0. out, out_sel and sel_err hold their values.
  - If out_valid && !out_ready, out, out_sel and sel_err are held stable.
  - Simultaneous consume and accept: the new data replaces the old in the same edge and out_valid stays 1.
  - out is not re-sampled if in changes after capture.
- Scan mode (mode_q = 1):
  - sel_ready = 0; select and sel_valid are ignored; out_ready is ignored.
  - Divider counts 0..SCAN_DIV-1. At terminal count:
    - divider <= 0
    - scan index <= (index == CHANNELS-1) ? 0 : index+1
    - scan_tick <= 1 for exactly one cycle
  - Otherwise divider increments and scan_tick <= 0.
  - With SCAN_DIV = 1, scan_tick stays high continuously and the index advances every edge.
  - Every edge: out <= channel[index] (live tracking of in, 1-cycle latency), out_sel <= index, out_valid <= 1, sel_err <= 0.
- Arithmetic:
  - Channel slicing uses indexed part-select `select*WIDTH +: WIDTH`, guarded by the range check.
  - Index and divider counters never exceed CHANNELS-1 and SCAN_DIV-1.
  - Divider width is clog2(SCAN_DIV), minimum 1.

Test Plan:
1. Reset then direct mode; in channel k = 8'h11*k; select=5, sel_valid=1 for one cycle -> next cycle out=8'h55, out_sel=5, out_valid=1, sel_err=0.
2. Backpressure: out_ready=0, request 3 then hold sel_valid with select=9 -> sel_ready=0, out stays 8'h33. Raise out_ready -> same edge loads 8'h99 and out_valid stays 1.
3. CHANNELS=12, SEL_W=4: select=14 -> out=0, sel_err=1, out_sel=14. Next valid select=2 -> sel_err=0, out=8'h22.
4. Scan with SCAN_DIV=4, CHANNELS=16 -> scan_tick every 4th cycle. out_sel goes 0,1,…,15,0 and out=8'h11*out_sel. Change in[7] mid-dwell -> out follows within 1 cycle.
5. Mode switch with a pending direct result (out_valid=1, out_ready=0) -> switch edge gives out_valid=0, scan starts at index 0. Switch back -> out_valid=0 until the next handshake.
6. Assert rst_n low asynchronously mid-scan (index 6) -> outputs 0 immediately without a clk edge. After release, the block is in direct mode with index 0.
